// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: forwarding selects, load-use
// stall, multi-cycle (mul/div) hold in ID, branch flush and a stall counter.
module pipe_hazard_ctrl #(
    parameter int MDU_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        duse_rs,
    input  logic        duse_rt,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  mrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        dbranch_taken,
    input  logic        dmdu_start,
    output logic        wpcir,
    output logic        dbubble,
    output logic        dflush,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        mdu_busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_WAIT = 2'd1,
        MDU_DONE = 2'd2
    } state_t;

    // The accept cycle in IDLE is the first held cycle, so the counter covers
    // the remaining MDU_CYCLES-1 cycles spent in MDU_WAIT.
    localparam logic [7:0] CNT_LOAD = 8'(MDU_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        hold;
    logic        lu;
    logic [1:0]  fwda_raw, fwdb_raw;

    // Operand source select; EXE wins over MEM, r0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] s,
        input logic [4:0] e_rn, input logic e_wreg, input logic e_m2reg,
        input logic [4:0] m_rn, input logic m_wreg, input logic m_m2reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (e_wreg && (e_rn != 5'd0) && (e_rn == s) && !e_m2reg)
            sel = 2'b01;
        else if (m_wreg && m_m2reg && (m_rn != 5'd0) && (m_rn == s))
            sel = 2'b11;
        else if (m_wreg && (m_rn != 5'd0) && (m_rn == s))
            sel = 2'b10;
        return sel;
    endfunction

    // Forwarding selects and load-use detection.
    always_comb begin
        fwda_raw = fwd_sel(drs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
        fwdb_raw = fwd_sel(drt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
        lu = ewreg && em2reg && (ern != 5'd0) &&
             ((duse_rs && (ern == drs)) || (duse_rt && (ern == drt)));
    end

    // Next-state logic and the internal hold request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (lu) begin
                    hold = 1'b1;
                end else if (dmdu_start) begin
                    hold    = 1'b1;
                    state_d = MDU_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            MDU_WAIT: begin
                hold  = 1'b1;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1)
                    state_d = MDU_DONE;
            end
            MDU_DONE: begin
                // The released mul/div may still depend on a load in EXE.
                if (lu)
                    hold = 1'b1;
                else
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        stall_d = stall_q;
        if (hold && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    // State, MDU countdown and stall counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Outputs are forced to their reset values while reset is asserted.
    always_comb begin
        wpcir     = !reset && !hold;
        dbubble   = reset || hold;
        dflush    = dbranch_taken && wpcir;
        fwda      = reset ? 2'b00 : fwda_raw;
        fwdb      = reset ? 2'b00 : fwdb_raw;
        mdu_busy  = (state_q == MDU_WAIT);
        stall_cnt = stall_q;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MDU_CYCLES, default 8, range 2..255: number of cycles a multi-cycle (mul/div) instruction is held in ID.
REQ-002 Clock and reset: one clock, reset asynchronous active-high.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-high; forces every register to its reset value.
REQ-005 drs, drt  in  5 each  ID-stage source register numbers.
REQ-006 duse_rs, duse_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-007 ern, ewreg, em2reg  in  5/1/1  EXE-stage destination, write-enable, load flag.
REQ-008 mrn, mwreg, mm2reg  in  5/1/1  MEM-stage destination, write-enable, load flag.
REQ-009 dbranch_taken  in  1  branch or jump resolved taken in ID.
REQ-010 dmdu_start  in  1  ID instruction is a multi-cycle op.
REQ-011 wpcir  out  1  1 = PC and IF/ID advance; 0 = hold.
REQ-012 dbubble  out  1  1 = ID/EXE register loads all-zero control (nop).
REQ-013 dflush  out  1  1 = IF/ID loads nop on the next edge.
REQ-014 fwda, fwdb  out  2 each  operand select: 00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data.
REQ-015 mdu_busy  out  1  high while in MDU_WAIT.
REQ-016 stall_cnt  out  16  count of cycles with wpcir=0.

Function
REQ-017 Forwarding (combinational), per operand with source s: 01 if ewreg & ern!=0 & ern==s & !em2reg; else 11 if mwreg & mm2reg & mrn!=0 & mrn==s; else 10 if mwreg & mrn!=0 & mrn==s; else 00.
REQ-018 EXE match SHALL take priority over MEM match; register 0 never forwards.
REQ-019 Load-use hazard lu = ewreg & em2reg & ern!=0 & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).
REQ-020 lu in IDLE or MDU_DONE: wpcir=0 and dbubble=1 in the same cycle; no state change. The stall lasts one cycle because the load then sits in MEM and is forwarded with code 11.
REQ-021 FSM states: IDLE, MDU_WAIT, MDU_DONE. The reset state is IDLE.
REQ-022 IDLE & dmdu_start & !lu: go to MDU_WAIT and load cnt=MDU_CYCLES-1. In that cycle wpcir=0 and dbubble=1.
REQ-023 MDU_WAIT: wpcir=0 and dbubble=1. cnt decrements each cycle; at cnt==1 go to MDU_DONE. Total hold is exactly MDU_CYCLES cycles.
REQ-024 MDU_DONE: the instruction is released (wpcir=1, dbubble=0 unless lu) and dmdu_start is ignored; the next state is IDLE.
REQ-025 lu SHALL block MDU start. The FSM stays IDLE until lu clears.
REQ-026 dflush = dbranch_taken & wpcir. A taken branch during a stall is not flushed and is re-evaluated.
REQ-027 stall_cnt increments on each edge where wpcir=0, and saturates at 16'hFFFF.
REQ-028 No other combination of inputs changes state.

Reset
REQ-029 While reset is high: state=IDLE, cnt=0, stall_cnt=0, mdu_busy=0, wpcir=0, dbubble=1, dflush=0, fwda=fwdb=00.
REQ-030 Reset asserted in MDU_WAIT SHALL abort the operation immediately. After deassert the FSM is in IDLE and the held instruction re-triggers if dmdu_start is still high.
REQ-031 The first rising edge after deassert is normal operation.

Verification
REQ-032 EXE add writes r5 with ID reading rs=r5, and MEM also writes r5 -> fwda=01 (EXE priority); drs=0 with ern=0 -> fwda=00.
REQ-033 Load r7 in EXE with ID reading rt=r7 -> one cycle of wpcir=0, dbubble=1, stall_cnt 0->1; next cycle fwdb=11 and wpcir=1.
REQ-034 MDU_CYCLES=8, dmdu_start held high from IDLE -> wpcir=0 for exactly 8 cycles and mdu_busy high for 7. wpcir=1 in the 9th cycle (MDU_DONE). IDLE in the 10th, where a new dmdu_start is accepted.
REQ-035 dbranch_taken=1 with wpcir=1 -> dflush=1; dbranch_taken=1 coincident with lu -> dflush=0.
REQ-036 Reset pulsed at the 3rd MDU_WAIT cycle -> outputs take reset values asynchronously. After release with dmdu_start high, a fresh 8-cycle hold occurs.
REQ-037 Force 70000 stall cycles -> stall_cnt holds at 16'hFFFF.
